// File: rtl/pc_pkg.sv
// Shared definitions for the PC/branch unit: opcodes, FSM encoding and
// the control-flow decode helper.
package pc_pkg;

  // Control-flow opcodes (instr[IW-2:IW-3])
  localparam logic [1:0] OP_RET  = 2'b00;  // also JZ when target != 0
  localparam logic [1:0] OP_JNZ  = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_JMP  = 2'b11;

  // Instruction issued to the datapath to place the zero flag on the bus
  localparam logic [7:0] FLAG_RD_OP = 8'h0A;

  // FSM encoding
  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_FETCH       = 2'd0;
  localparam logic [ST_W-1:0] ST_FLAG_REQ    = 2'd1;
  localparam logic [ST_W-1:0] ST_FLAG_SAMPLE = 2'd2;

  typedef struct packed {
    logic       is_ctrl;
    logic [1:0] op;
  } ctrl_dec_t;

  // Decode from the top four instruction bits {IW-1, IW-2, IW-3, IW-4}
  function automatic ctrl_dec_t pc_decode(input logic [3:0] hi);
    ctrl_dec_t d;
    d.is_ctrl = ~hi[3] & hi[0];
    d.op      = hi[2:1];
    return d;
  endfunction

endpackage

// File: rtl/pc_branch_unit_ret_stack.sv
// Bounded LIFO of return addresses used by CALL/RET.
module ret_stack
  import pc_pkg::*;
#(
  parameter int unsigned AW          = 4,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] top
);

  localparam int unsigned SPW  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDXW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [SPW-1:0] sp;
  logic [AW-1:0]  mem [STACK_DEPTH];

  assign full  = (sp == SPW'(STACK_DEPTH));
  assign empty = (sp == SPW'(0));
  assign top   = mem[IDXW'(sp - SPW'(1))];

  // Stack pointer; the caller never pushes when full nor pops when empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SPW'(1);
    end else if (pop && !empty) begin
      sp <= sp - SPW'(1);
    end
  end

  // Entry storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[IDXW'(sp)] <= push_data;
    end
  end

endmodule

// File: rtl/pc_branch_unit.sv
// PC and control-flow unit: fetches one instruction per handshake, issues
// non-control instructions, resolves JMP/JNZ/JZ/CALL/RET internally.
// Optional build macro: PC_HALT_DETECT_EN (JMP-to-self halts the unit).
module pc_branch_unit
  import pc_pkg::*;
#(
  parameter int unsigned AW          = 4,
  parameter int unsigned IW          = 8,
  parameter int unsigned DW          = 4,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] instr_in,
  input  logic          instr_valid,
  output logic          instr_ready,
  output logic [AW-1:0] pc,
  output logic [IW-1:0] instr_out,
  output logic          instr_out_valid,
  input  logic [DW-1:0] bus_in,
  output logic          stack_err,
  output logic          halted
);

  logic [ST_W-1:0] state, state_n;
  logic [AW-1:0]   pc_n, pc_inc, target, tgt_q, tgt_n, stk_top;
  logic [IW-1:0]   instr_out_n;
  logic            valid_n, err_n, halted_n, ready_n;
  logic            jz_q, jz_n;
  logic            push, pop, stk_full, stk_empty, zflag;
  ctrl_dec_t       dec;

  logic unused_bus;
  assign unused_bus = ^bus_in[DW-1:1];

  assign dec    = pc_decode(instr_in[IW-1:IW-4]);
  assign target = instr_in[AW-1:0];
  assign pc_inc = pc + AW'(1);
  assign zflag  = bus_in[0];

  ret_stack #(
    .AW          (AW),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .full      (stk_full),
    .empty     (stk_empty),
    .top       (stk_top)
  );

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    instr_out_n = instr_out;
    valid_n     = 1'b0;
    err_n       = stack_err;
    halted_n    = halted;
    tgt_n       = tgt_q;
    jz_n        = jz_q;
    push        = 1'b0;
    pop         = 1'b0;

    case (state)
      ST_FETCH: begin
        if (instr_valid && instr_ready) begin
          if (!dec.is_ctrl) begin
            instr_out_n = instr_in;
            valid_n     = 1'b1;
            pc_n        = pc_inc;
          end else begin
            case (dec.op)
              OP_JMP: begin
                pc_n = target;
`ifdef PC_HALT_DETECT_EN
                if (target == pc) begin
                  halted_n = 1'b1;
                end
`endif
              end
              OP_CALL: begin
                if (!stk_full) begin
                  push = 1'b1;
                  pc_n = target;
                end else begin
                  err_n = 1'b1;
                  pc_n  = pc_inc;
                end
              end
              OP_RET: begin
                if (target != AW'(0)) begin
                  // JZ: branch when the zero flag is set
                  tgt_n       = target;
                  jz_n        = 1'b1;
                  instr_out_n = IW'(FLAG_RD_OP);
                  valid_n     = 1'b1;
                  state_n     = ST_FLAG_REQ;
                end else if (!stk_empty) begin
                  pop  = 1'b1;
                  pc_n = stk_top;
                end else begin
                  err_n = 1'b1;
                  pc_n  = pc_inc;
                end
              end
              default: begin
                // JNZ: branch when the zero flag is clear
                tgt_n       = target;
                jz_n        = 1'b0;
                instr_out_n = IW'(FLAG_RD_OP);
                valid_n     = 1'b1;
                state_n     = ST_FLAG_REQ;
              end
            endcase
          end
        end
      end
      ST_FLAG_REQ: begin
        state_n = ST_FLAG_SAMPLE;
      end
      ST_FLAG_SAMPLE: begin
        pc_n    = (zflag == jz_q) ? tgt_q : pc_inc;
        state_n = ST_FETCH;
      end
      default: begin
        state_n = ST_FETCH;
      end
    endcase

    ready_n = (state_n == ST_FETCH) && !halted_n;
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_FETCH;
      pc              <= '0;
      instr_out       <= '0;
      instr_out_valid <= 1'b0;
      stack_err       <= 1'b0;
      halted          <= 1'b0;
      instr_ready     <= 1'b1;
      tgt_q           <= '0;
      jz_q            <= 1'b0;
    end else begin
      state           <= state_n;
      pc              <= pc_n;
      instr_out       <= instr_out_n;
      instr_out_valid <= valid_n;
      stack_err       <= err_n;
      halted          <= halted_n;
      instr_ready     <= ready_n;
      tgt_q           <= tgt_n;
      jz_q            <= jz_n;
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed, table-driven bench for pc_branch_unit (default parameters).
module tb_pc_branch_unit;

  logic       clk;
  logic       rst_n;
  logic [7:0] instr_in;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] pc;
  logic [7:0] instr_out;
  logic       instr_out_valid;
  logic [3:0] bus_in;
  logic       stack_err;
  logic       halted;

  int n_checks = 0;
  int n_fail   = 0;

  pc_branch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .instr_in        (instr_in),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .pc              (pc),
    .instr_out       (instr_out),
    .instr_out_valid (instr_out_valid),
    .bus_in          (bus_in),
    .stack_err       (stack_err),
    .halted          (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] instr;
    logic       valid;
    logic [3:0] bus;
    logic [3:0] exp_pc;
    logic       exp_ov;
    logic [7:0] exp_io;
    logic       exp_rdy;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [7:0] instr, logic valid, logic [3:0] bus,
                              logic [3:0] epc, logic eov, logic [7:0] eio,
                              logic erdy, logic eerr);
    vec_t v;
    v.instr = instr; v.valid = valid; v.bus = bus;
    v.exp_pc = epc; v.exp_ov = eov; v.exp_io = eio;
    v.exp_rdy = erdy; v.exp_err = eerr;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(logic [7:0] instr, logic valid, logic [3:0] bus);
    instr_in    = instr;
    instr_valid = valid;
    bus_in      = bus;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_in    = '0;
    instr_valid = 1'b0;
    bus_in      = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    check("rst_pc", pc, 0);
    check("rst_ov", instr_out_valid, 0);
    check("rst_io", instr_out, 0);
    check("rst_err", stack_err, 0);
    check("rst_halt", halted, 0);
    check("rst_rdy", instr_ready, 1);

    // 17 plain instructions: pc 1..15, 0, 1
    for (int i = 0; i < 17; i++)
      vecs.push_back(mk(8'(8'h80 + i), 1, 0, 4'((i + 1) % 16), 1, 8'(8'h80 + i), 1, 0));
    vecs.push_back(mk(8'h81, 1, 0, 4'd2, 1, 8'h81, 1, 0));
    // JNZ 7 at pc=2, z=0 -> taken; instr_valid held high while busy is ignored
    vecs.push_back(mk(8'h37, 1, 0, 4'd2, 1, 8'h0A, 0, 0));
    vecs.push_back(mk(8'h85, 1, 0, 4'd2, 0, 8'h00, 0, 0));
    vecs.push_back(mk(8'h85, 1, 0, 4'd7, 0, 8'h00, 1, 0));
    // JMP 2
    vecs.push_back(mk(8'h72, 1, 0, 4'd2, 0, 8'h00, 1, 0));
    // JNZ 7 at pc=2, z=1 -> not taken
    vecs.push_back(mk(8'h37, 1, 1, 4'd2, 1, 8'h0A, 0, 0));
    vecs.push_back(mk(8'h00, 0, 1, 4'd2, 0, 8'h00, 0, 0));
    vecs.push_back(mk(8'h00, 0, 1, 4'd3, 0, 8'h00, 1, 0));
    // JMP 9 at pc=3
    vecs.push_back(mk(8'h79, 1, 0, 4'd9, 0, 8'h00, 1, 0));
    // JZ 5 at pc=9, z=1 -> taken
    vecs.push_back(mk(8'h15, 1, 1, 4'd9, 1, 8'h0A, 0, 0));
    vecs.push_back(mk(8'h00, 0, 1, 4'd9, 0, 8'h00, 0, 0));
    vecs.push_back(mk(8'h00, 0, 1, 4'd5, 0, 8'h00, 1, 0));
    // idle holds
    vecs.push_back(mk(8'h81, 0, 0, 4'd5, 0, 8'h00, 1, 0));
    // Five nested CALLs, depth 4: pushes 6, 9, 13, 2; fifth errors
    vecs.push_back(mk(8'h58, 1, 0, 4'd8,  0, 8'h00, 1, 0));
    vecs.push_back(mk(8'h5C, 1, 0, 4'd12, 0, 8'h00, 1, 0));
    vecs.push_back(mk(8'h51, 1, 0, 4'd1,  0, 8'h00, 1, 0));
    vecs.push_back(mk(8'h50, 1, 0, 4'd0,  0, 8'h00, 1, 0));
    vecs.push_back(mk(8'h54, 1, 0, 4'd1,  0, 8'h00, 1, 1));
    // Four RETs in LIFO order, fifth on empty stack
    vecs.push_back(mk(8'h10, 1, 0, 4'd2,  0, 8'h00, 1, 1));
    vecs.push_back(mk(8'h10, 1, 0, 4'd13, 0, 8'h00, 1, 1));
    vecs.push_back(mk(8'h10, 1, 0, 4'd9,  0, 8'h00, 1, 1));
    vecs.push_back(mk(8'h10, 1, 0, 4'd6,  0, 8'h00, 1, 1));
    vecs.push_back(mk(8'h10, 1, 0, 4'd7,  0, 8'h00, 1, 1));
    // CALL at pc=15 pushes wrapped 0
    vecs.push_back(mk(8'h7F, 1, 0, 4'd15, 0, 8'h00, 1, 1));
    vecs.push_back(mk(8'h53, 1, 0, 4'd3,  0, 8'h00, 1, 1));
    vecs.push_back(mk(8'h10, 1, 0, 4'd0,  0, 8'h00, 1, 1));
    // JZ 5 at pc=0, z=0 -> not taken
    vecs.push_back(mk(8'h15, 1, 0, 4'd0, 1, 8'h0A, 0, 1));
    vecs.push_back(mk(8'h00, 0, 0, 4'd0, 0, 8'h00, 0, 1));
    vecs.push_back(mk(8'h00, 0, 0, 4'd1, 0, 8'h00, 1, 1));

    foreach (vecs[k]) begin
      step(vecs[k].instr, vecs[k].valid, vecs[k].bus);
      check($sformatf("v%0d_pc", k), pc, vecs[k].exp_pc);
      check($sformatf("v%0d_ov", k), instr_out_valid, vecs[k].exp_ov);
      if (vecs[k].exp_ov)
        check($sformatf("v%0d_io", k), instr_out, vecs[k].exp_io);
      check($sformatf("v%0d_rdy", k), instr_ready, vecs[k].exp_rdy);
      check($sformatf("v%0d_err", k), stack_err, vecs[k].exp_err);
      check($sformatf("v%0d_halt", k), halted, 0);
    end

    // Reset during FLAG_SAMPLE of a JNZ that would be taken
    step(8'h37, 1, 0);
    step(8'h00, 0, 0);
    check("abort_in_sample_rdy", instr_ready, 0);
    rst_n = 1'b0;
    #1;
    check("abort_pc", pc, 0);
    check("abort_ov", instr_out_valid, 0);
    check("abort_rdy", instr_ready, 1);
    check("abort_err", stack_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h00, 0, 0);
    check("abort_next_pc", pc, 0);
    check("abort_next_ov", instr_out_valid, 0);
    check("abort_next_rdy", instr_ready, 1);

    // JMP-to-self at pc=5
    step(8'h75, 1, 0);
    check("halt_pre_pc", pc, 5);
    check("halt_pre_halt", halted, 0);
    step(8'h75, 1, 0);
    check("halt_pc", pc, 5);
`ifdef PC_HALT_DETECT_EN
    check("halt_flag", halted, 1);
    check("halt_rdy", instr_ready, 0);
    step(8'h81, 1, 0);
    check("halt_hold_pc", pc, 5);
    check("halt_hold_ov", instr_out_valid, 0);
    check("halt_hold_flag", halted, 1);
`else
    check("halt_flag", halted, 0);
    check("halt_rdy", instr_ready, 1);
    step(8'h81, 1, 0);
    check("halt_next_pc", pc, 6);
    check("halt_next_ov", instr_out_valid, 1);
    check("halt_next_io", instr_out, 8'h81);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
